// File: rtl/fifo_pkg.sv
// Shared FIFO package: default geometry, threshold-range limits and a
// clog2-style helper reused by the FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_AF_THRESH = 14;
  localparam int DEF_AE_THRESH = 2;

  // Legal threshold ranges are AF in 1..DEPTH and AE in 0..DEPTH-1
  localparam int AF_MIN = 1;
  localparam int AE_MIN = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic bit thresh_ok(
    input int af,
    input int ae,
    input int depth
  );
    return (af >= AF_MIN) && (af <= depth) &&
           (ae >= AE_MIN) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM; read is async when PARAM_SYNC_FIFO_FWFT_EN is
// defined, otherwise registered with an async-reset output register.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = rst | re;
  assign rdata     = mem[raddr];
`else
  logic [DATA_W-1:0] q;

  // A same-address write on a full push/pop returns the old word
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[raddr];
  end

  assign rdata = q;
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, thresholds and
// sticky errors; PARAM_SYNC_FIFO_FWFT_EN selects first-word-fall-through.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CW'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C    = CW'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = CW'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] ram_q;

  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  always_comb begin
    count_nxt = count;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Flags come from count_nxt so they line up with count itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr + ADDR_W'(wr_acc);
      rd_ptr       <= rd_ptr + ADDR_W'(rd_acc);
      count        <= count_nxt;
      full         <= count_nxt == DEPTH_C;
      empty        <= count_nxt == '0;
      almost_full  <= count_nxt >= AF_C;
      almost_empty <= count_nxt <= AE_C;
      if (err_clr) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en & ~wr_acc) overflow  <= 1'b1;
        if (rd_en & ~rd_acc) underflow <= 1'b1;
      end
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign dout = empty ? '0 : ram_q;
`else
  assign dout = ram_q;
`endif

endmodule
